// File: rtl/axil_regbank_slave.sv
// AXI4-Lite slave register bank: control, status, free-running counter with compare,
// and four scratch registers. Write and read channels run independent FSMs.
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*      AXI4-Lite write address, write data and write response channels
//   s_axi_ar*/r*         AXI4-Lite read address and read data channels
//   cnt_match            one-cycle pulse, registered COUNTER == COMPARE while enabled
//
// Map (addr[11:0]): 0x00 CTRL, 0x04 STATUS, 0x08 COUNTER, 0x0C COMPARE, 0x10-0x1C SCRATCH0-3.
// Offsets >= 0x20 or misaligned addresses respond SLVERR.
module axil_regbank_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  cnt_match
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic {WIdle, WResp} wstate_e;
  typedef enum logic {RIdle, RData} rstate_e;

  // Only offsets 0x00-0x1C, word aligned, are mapped.
  function automatic logic addr_err(input logic [11:0] a);
    return (|a[11:5]) | (|a[1:0]);
  endfunction

  // Upper address bits are not decoded.
  logic unused_addr;
  assign unused_addr = ^{s_axi_awaddr[ADDR_WIDTH-1:12], s_axi_araddr[ADDR_WIDTH-1:12]};

  // Write channel state
  wstate_e                wstate_q, wstate_d;
  logic                   aw_got_q, aw_got_d;
  logic                   w_got_q, w_got_d;
  logic [11:0]            awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic                   awready_q, awready_d;
  logic                   wready_q, wready_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;

  // Read channel state
  rstate_e                rstate_q, rstate_d;
  logic                   arready_q, arready_d;
  logic                   rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;

  // Register bank
  logic                   en_q, en_d;
  logic [7:0]             wcnt_q, wcnt_d;
  logic [DATA_WIDTH-1:0]  counter_q, counter_d;
  logic [DATA_WIDTH-1:0]  compare_q, compare_d;
  logic [3:0][DATA_WIDTH-1:0] scratch_q, scratch_d;
  logic                   match_q, match_d;

  logic                   aw_hs, w_hs, ar_hs;
  logic                   commit, commit_err, clr, ar_err;
  logic [11:0]            commit_addr, ar_off;
  logic [DATA_WIDTH-1:0]  commit_data, rd_val;

  assign aw_hs = s_axi_awvalid & awready_q;
  assign w_hs  = s_axi_wvalid & wready_q;
  assign ar_hs = s_axi_arvalid & arready_q;

  // The commit uses whichever of AW/W was captured earlier, else the live bus value.
  assign commit_addr = aw_got_q ? awaddr_q : s_axi_awaddr[11:0];
  assign commit_data = w_got_q ? wdata_q : s_axi_wdata;
  assign commit_err  = addr_err(commit_addr);

  assign ar_off = s_axi_araddr[11:0];
  assign ar_err = addr_err(ar_off);

  // Write FSM
  always_comb begin
    wstate_d  = wstate_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    commit    = 1'b0;
    unique case (wstate_q)
      WIdle: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          awaddr_d = s_axi_awaddr[11:0];
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = s_axi_wdata;
        end
        if ((aw_got_q | aw_hs) && (w_got_q | w_hs)) begin
          commit    = 1'b1;
          wstate_d  = WResp;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = commit_err ? RespSlverr : RespOkay;
        end else begin
          awready_d = ~(aw_got_q | aw_hs);
          wready_d  = ~(w_got_q | w_hs);
        end
      end
      WResp: begin
        if (s_axi_bready) begin
          wstate_d  = WIdle;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
    endcase
  end

  // Read mux of current register values
  always_comb begin
    rd_val = '0;
    unique case (ar_off[4:2])
      3'd0: rd_val[0] = en_q;
      3'd1: begin
        rd_val[0]    = en_q;
        rd_val[15:8] = wcnt_q;
      end
      3'd2:    rd_val = counter_q;
      3'd3:    rd_val = compare_q;
      default: rd_val = scratch_q[ar_off[3:2]];
    endcase
  end

  // Read FSM
  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (rstate_q)
      RIdle: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          rstate_d  = RData;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = ar_err ? '0 : rd_val;
          rresp_d   = ar_err ? RespSlverr : RespOkay;
        end
      end
      RData: begin
        if (s_axi_rready) begin
          rstate_d  = RIdle;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end
    endcase
  end

  // Register updates; counter priority is CLR > EN increment > hold.
  always_comb begin
    en_d      = en_q;
    compare_d = compare_q;
    scratch_d = scratch_q;
    wcnt_d    = wcnt_q;
    clr       = 1'b0;
    if (commit && !commit_err) begin
      wcnt_d = wcnt_q + 8'd1;
      unique case (commit_addr[4:2])
        3'd0: begin
          en_d = commit_data[0];
          clr  = commit_data[1];
        end
        3'd3:                   compare_d = commit_data;
        3'd4, 3'd5, 3'd6, 3'd7: scratch_d[commit_addr[3:2]] = commit_data;
        default: ; // STATUS and COUNTER ignore writes
      endcase
    end
    if (clr) begin
      counter_d = '0;
    end else if (en_q) begin
      counter_d = counter_q + DATA_WIDTH'(1);
    end else begin
      counter_d = counter_q;
    end
    match_d = en_q && (counter_q == compare_q);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate_q  <= WIdle;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      rstate_q  <= RIdle;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
      en_q      <= 1'b0;
      wcnt_q    <= '0;
      counter_q <= '0;
      compare_q <= '0;
      scratch_q <= '0;
      match_q   <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      en_q      <= en_d;
      wcnt_q    <= wcnt_d;
      counter_q <= counter_d;
      compare_q <= compare_d;
      scratch_q <= scratch_d;
      match_q   <= match_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign cnt_match     = match_q;

endmodule

// File: tb/tb_axil_regbank_slave.sv
// Self-checking bench for axil_regbank_slave: a table of directed write/read vectors followed
// by hand-written sequences for split AW/W, backpressure, counter/compare and mid-flight reset.
module tb_axil_regbank_slave;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [31:0] s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic        cnt_match;

  int checks = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  axil_regbank_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .cnt_match    (cnt_match)
  );

  typedef struct {
    bit          wr;    // 1: write, 0: read
    logic [31:0] addr;
    logic [31:0] data;  // write data, or expected read data
    logic [1:0]  resp;  // expected response
  } vec_t;

  localparam int NV = 25;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           output logic [1:0] resp);
    bit aw_pend, w_pend, aw_fire, w_fire, done;
    int n;
    aw_pend = 1'b1;
    w_pend  = 1'b1;
    done    = 1'b0;
    n       = 0;
    resp    = 2'b11;
    s_axi_awaddr  = addr;
    s_axi_wdata   = data;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    s_axi_bready  = 1'b1;
    while ((aw_pend || w_pend) && n < 20) begin
      aw_fire = aw_pend && s_axi_awready;
      w_fire  = w_pend && s_axi_wready;
      step();
      n++;
      if (aw_fire) begin
        s_axi_awvalid = 1'b0;
        aw_pend = 1'b0;
      end
      if (w_fire) begin
        s_axi_wvalid = 1'b0;
        w_pend = 1'b0;
      end
    end
    while (!done && n < 40) begin
      if (s_axi_bvalid) begin
        resp = s_axi_bresp;
        done = 1'b1;
      end
      step();
      n++;
    end
    s_axi_bready  = 1'b0;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL write_timeout: addr %h got no response, expected bvalid", addr);
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    bit pend, fire, done;
    int n;
    pend = 1'b1;
    done = 1'b0;
    n    = 0;
    data = 32'hxxxx_xxxx;
    resp = 2'b11;
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = 1'b1;
    while (pend && n < 20) begin
      fire = s_axi_arready;
      step();
      n++;
      if (fire) begin
        s_axi_arvalid = 1'b0;
        pend = 1'b0;
      end
    end
    while (!done && n < 40) begin
      if (s_axi_rvalid) begin
        data = s_axi_rdata;
        resp = s_axi_rresp;
        done = 1'b1;
      end
      step();
      n++;
    end
    s_axi_rready  = 1'b0;
    s_axi_arvalid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL read_timeout: addr %h got no data, expected rvalid", addr);
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd, r1, r2;
    int          first_k, pulses;

    // wr, addr, data/expected rdata, expected resp
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hA5A5_0001, 2'b00};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'hA5A5_0001, 2'b00};
    vecs[2]  = '{1'b0, 32'h0000_0004, 32'h0000_0100, 2'b00};
    vecs[3]  = '{1'b1, 32'h0000_0024, 32'h1234_5678, 2'b10};
    vecs[4]  = '{1'b0, 32'h0000_0024, 32'h0000_0000, 2'b10};
    vecs[5]  = '{1'b0, 32'h0000_000E, 32'h0000_0000, 2'b10};
    vecs[6]  = '{1'b0, 32'h0000_0004, 32'h0000_0100, 2'b00};
    vecs[7]  = '{1'b1, 32'h0000_0014, 32'h1234_5678, 2'b00};
    vecs[8]  = '{1'b1, 32'h0000_0018, 32'hDEAD_BEEF, 2'b00};
    vecs[9]  = '{1'b1, 32'h0000_001C, 32'hCAFE_F00D, 2'b00};
    vecs[10] = '{1'b1, 32'h0000_000C, 32'h0000_0055, 2'b00};
    vecs[11] = '{1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 2'b00};
    vecs[12] = '{1'b0, 32'h0000_0008, 32'h0000_0000, 2'b00};
    vecs[13] = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 2'b00};
    vecs[14] = '{1'b0, 32'h0000_0004, 32'h0000_0700, 2'b00};
    vecs[15] = '{1'b0, 32'h0000_0014, 32'h1234_5678, 2'b00};
    vecs[16] = '{1'b0, 32'h0000_0018, 32'hDEAD_BEEF, 2'b00};
    vecs[17] = '{1'b0, 32'h0000_001C, 32'hCAFE_F00D, 2'b00};
    vecs[18] = '{1'b0, 32'h0000_000C, 32'h0000_0055, 2'b00};
    vecs[19] = '{1'b1, 32'h0000_0011, 32'h0BAD_0BAD, 2'b10};
    vecs[20] = '{1'b0, 32'h0000_0010, 32'hA5A5_0001, 2'b00};
    vecs[21] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 2'b00};
    vecs[22] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 2'b00};
    vecs[23] = '{1'b0, 32'h0000_1010, 32'hA5A5_0001, 2'b00};
    vecs[24] = '{1'b0, 32'h0000_0004, 32'h0000_0800, 2'b00};

    // Reset state
    #12;
    chk("rst_awready", s_axi_awready, 0);
    chk("rst_wready", s_axi_wready, 0);
    chk("rst_arready", s_axi_arready, 0);
    chk("rst_bvalid", s_axi_bvalid, 0);
    chk("rst_rvalid", s_axi_rvalid, 0);
    chk("rst_bresp", s_axi_bresp, 0);
    chk("rst_rresp", s_axi_rresp, 0);
    chk("rst_rdata", s_axi_rdata, 0);
    chk("rst_cnt_match", cnt_match, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    step();
    chk("post_rst_awready", s_axi_awready, 1);
    chk("post_rst_wready", s_axi_wready, 1);
    chk("post_rst_arready", s_axi_arready, 1);

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, resp);
        chk($sformatf("vec%0d_bresp", i), resp, vecs[i].resp);
      end else begin
        axi_read(vecs[i].addr, rd, resp);
        chk($sformatf("vec%0d_rresp", i), resp, vecs[i].resp);
        chk($sformatf("vec%0d_rdata", i), rd, vecs[i].data);
      end
    end

    // Split AW/W with response backpressure; a read racing the commit sees the old value.
    step();
    s_axi_awaddr  = 32'h10;
    s_axi_awvalid = 1'b1;
    chk("split_awready_c0", s_axi_awready, 1);
    step();  // cycle 1
    s_axi_awvalid = 1'b0;
    chk("split_awready_c1", s_axi_awready, 0);
    chk("split_bvalid_c1", s_axi_bvalid, 0);
    step();  // cycle 2
    chk("split_bvalid_c2", s_axi_bvalid, 0);
    step();  // cycle 3
    chk("split_awready_c3", s_axi_awready, 0);
    chk("split_wready_c3", s_axi_wready, 1);
    chk("split_bvalid_c3", s_axi_bvalid, 0);
    s_axi_wdata   = 32'h1111_2222;
    s_axi_wvalid  = 1'b1;
    s_axi_araddr  = 32'h10;
    s_axi_arvalid = 1'b1;
    step();  // cycle 4
    s_axi_wvalid  = 1'b0;
    s_axi_arvalid = 1'b0;
    chk("split_bvalid_c4", s_axi_bvalid, 1);
    chk("split_bresp_c4", s_axi_bresp, 0);
    chk("race_rvalid", s_axi_rvalid, 1);
    chk("race_rdata_old", s_axi_rdata, 32'hA5A5_0001);
    s_axi_rready = 1'b1;
    for (int k = 5; k <= 8; k++) begin
      step();
      s_axi_rready = 1'b0;
      chk($sformatf("hold_bvalid_c%0d", k), s_axi_bvalid, 1);
      chk($sformatf("hold_bresp_c%0d", k), s_axi_bresp, 0);
      chk($sformatf("hold_awready_c%0d", k), s_axi_awready, 0);
      chk($sformatf("hold_rvalid_c%0d", k), s_axi_rvalid, 0);
    end
    s_axi_bready = 1'b1;
    step();
    s_axi_bready = 1'b0;
    chk("split_bvalid_done", s_axi_bvalid, 0);
    chk("split_awready_back", s_axi_awready, 1);
    axi_read(32'h10, rd, resp);
    chk("split_readback", rd, 32'h1111_2222);

    // Counter/compare: COMPARE=10, CTRL=EN|CLR; pulse exactly 11 cycles after the commit.
    axi_write(32'h0C, 32'd10, resp);
    chk("cmp_bresp", resp, 0);
    s_axi_awaddr  = 32'h00;
    s_axi_wdata   = 32'h3;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    s_axi_bready  = 1'b1;
    step();  // commit cycle
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    chk("ctrl_commit_bvalid", s_axi_bvalid, 1);
    chk("ctrl_commit_match", cnt_match, 0);
    step();
    s_axi_bready = 1'b0;
    first_k = -1;
    pulses  = 0;
    for (int k = 1; k <= 20; k++) begin
      if (cnt_match) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
      if (k < 20) step();
    end
    chk("match_cycle", first_k, 11);
    chk("match_pulses", pulses, 1);
    axi_read(32'h08, r1, resp);
    axi_read(32'h08, r2, resp);
    chk("cnt_monotonic", (r2 > r1) ? 1 : 0, 1);
    chk("cnt_delta", r2 - r1, 2);
    axi_read(32'h04, rd, resp);
    chk("status_wcnt_en", rd, 32'h0000_0B01);

    // CLR while counting: zero in the commit cycle, 1 in the next (when the read samples it).
    axi_write(32'h00, 32'h3, resp);
    axi_read(32'h08, rd, resp);
    chk("clr_restart", rd, 32'd1);
    axi_write(32'h00, 32'h0, resp);
    axi_read(32'h08, r1, resp);
    axi_read(32'h08, r2, resp);
    chk("cnt_hold", r2, r1);

    // Reset with both responses pending.
    s_axi_awaddr  = 32'h14;
    s_axi_wdata   = 32'h7777_7777;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    s_axi_araddr  = 32'h14;
    s_axi_arvalid = 1'b1;
    step();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_arvalid = 1'b0;
    chk("pre_rst_bvalid", s_axi_bvalid, 1);
    chk("pre_rst_rvalid", s_axi_rvalid, 1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("midrst_bvalid", s_axi_bvalid, 0);
    chk("midrst_rvalid", s_axi_rvalid, 0);
    chk("midrst_rdata", s_axi_rdata, 0);
    chk("midrst_awready", s_axi_awready, 0);
    chk("midrst_arready", s_axi_arready, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    step();
    chk("rel_awready", s_axi_awready, 1);
    for (int a = 0; a < 8; a++) begin
      axi_read(32'(a * 4), rd, resp);
      chk($sformatf("rst_reg%0d", a), rd, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
